// File: rtl/exe_muldiv.sv
// Iterative 32-bit multiply (shift-add) / divide (restoring) unit for the EXE stage.
// Optional build macro MULDIV_FAST_MULT_EN: MULT/MULTU complete in one cycle.
module exe_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  opSel,
  input  logic        cancel,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic        hiWena,
  output logic        loWena,
  output logic        busy,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [4:0]  cnt;

  logic [63:0] acc_p0;
  logic [31:0] opb_p0;
  logic [31:0] dvd_p0;
  logic        div_p0;
  logic        neg_q_p0;
  logic        neg_r_p0;
  logic        div0_p0;

  logic        is_signed;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [32:0] add_sum;
  logic [32:0] trial;
  logic [63:0] acc_nxt;
  logic [63:0] prod_fin;
  logic [31:0] hi_fin;
  logic [31:0] lo_fin;
  logic        fast_go;
  logic [31:0] fast_hi;
  logic [31:0] fast_lo;

  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
    logic [31:0] r;
    r = (sgn && v[31]) ? (~v + 32'd1) : v;
    return r;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  assign is_signed = ~opSel[0];
  assign rs_mag    = mag32(rsData, is_signed);
  assign rt_mag    = mag32(rtData, is_signed);

  assign stall = ((state == IDLE) && start) || (state == CALC);
  assign busy  = (state == CALC);

`ifdef MULDIV_FAST_MULT_EN
  logic signed [63:0] fast_a;
  logic signed [63:0] fast_b;
  logic signed [63:0] fast_prod;
  always_comb begin
    fast_a    = opSel[0] ? {32'd0, rsData} : {{32{rsData[31]}}, rsData};
    fast_b    = opSel[0] ? {32'd0, rtData} : {{32{rtData[31]}}, rtData};
    fast_prod = fast_a * fast_b;
  end
  assign fast_go = ~opSel[1];
  assign fast_hi = fast_prod[63:32];
  assign fast_lo = fast_prod[31:0];
`else
  assign fast_go = 1'b0;
  assign fast_hi = 32'd0;
  assign fast_lo = 32'd0;
`endif

  // Iteration step: multiply adds the multiplicand into the upper half and shifts
  // right; divide shifts the remainder/quotient pair left and keeps the trial
  // subtract when it does not borrow. Final sign fix-up is applied on the last step.
  always_comb begin
    add_sum = {1'b0, acc_p0[63:32]} + {1'b0, opb_p0};
    trial   = acc_p0[63:31] - {1'b0, opb_p0};
    acc_nxt = acc_p0;
    if (!div_p0)
      acc_nxt = acc_p0[0] ? {add_sum, acc_p0[31:1]} : {1'b0, acc_p0[63:1]};
    else
      acc_nxt = trial[32] ? {acc_p0[62:0], 1'b0} : {trial[31:0], acc_p0[30:0], 1'b1};
    prod_fin = cond_neg64(acc_nxt, neg_q_p0);
    hi_fin   = prod_fin[63:32];
    lo_fin   = prod_fin[31:0];
    if (div_p0) begin
      if (div0_p0) begin
        hi_fin = dvd_p0;
        lo_fin = 32'hFFFF_FFFF;
      end else begin
        hi_fin = cond_neg32(acc_nxt[63:32], neg_r_p0);
        lo_fin = cond_neg32(acc_nxt[31:0], neg_q_p0);
      end
    end
  end

  // ---- operand latch / iteration datapath ----
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      acc_p0   <= {32'd0, opSel[1] ? rs_mag : rt_mag};
      opb_p0   <= opSel[1] ? rt_mag : rs_mag;
      dvd_p0   <= rsData;
      div_p0   <= opSel[1];
      neg_q_p0 <= is_signed & (rsData[31] ^ rtData[31]);
      neg_r_p0 <= is_signed & rsData[31];
      div0_p0  <= (rtData == 32'd0);
    end else if (state == CALC) begin
      acc_p0   <= acc_nxt;
    end
  end

  // ---- control FSM and registered results ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      hiOut  <= 32'd0;
      loOut  <= 32'd0;
      hiWena <= 1'b0;
      loWena <= 1'b0;
    end else begin
      hiWena <= 1'b0;
      loWena <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (fast_go) begin
              state  <= DONE;
              hiOut  <= fast_hi;
              loOut  <= fast_lo;
              hiWena <= 1'b1;
              loWena <= 1'b1;
            end else begin
              state <= CALC;
              cnt   <= 5'd0;
            end
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else if (cnt == 5'd31) begin
            state  <= DONE;
            hiOut  <= hi_fin;
            loOut  <= lo_fin;
            hiWena <= 1'b1;
            loWena <= 1'b1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed-vector bench for exe_muldiv: result values, latency, stall window,
// cancel, ignored start during CALC and reset mid-operation.
module tb_exe_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  opSel;
  logic        cancel;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        hiWena;
  logic        loWena;
  logic        busy;
  logic        stall;

  int total = 0;
  int bad   = 0;

  exe_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .opSel(opSel), .cancel(cancel),
    .rsData(rsData), .rtData(rtData), .hiOut(hiOut), .loOut(loOut),
    .hiWena(hiWena), .loWena(loWena), .busy(busy), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        poke;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] op);
`ifdef MULDIV_FAST_MULT_EN
    return op[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic poke, output int lat, output int stalls,
                       output logic [31:0] hi, output logic [31:0] lo, output logic busy1,
                       output logic [1:0] wen, output logic late_wen, output logic [31:0] hold_lo);
    lat = -1; stalls = 0; hi = '0; lo = '0; busy1 = 1'b0; wen = 2'b00;
    @(posedge clk); #1;
    start = 1'b1; opSel = op; rsData = a; rtData = b;
    #1 if (stall) stalls++;
    for (int cyc = 1; cyc <= 60 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      start = poke && (cyc == 5);
      if (poke && cyc == 5) begin
        opSel = 2'b01; rsData = 32'd0; rtData = 32'd0;
      end
      #1;
      if (cyc == 1) busy1 = busy;
      if (stall) stalls++;
      if (hiWena || loWena) begin
        lat = cyc; hi = hiOut; lo = loOut; wen = {hiWena, loWena};
      end
    end
    start = 1'b0;
    @(posedge clk); #2;
    late_wen = hiWena | loWena;
    hold_lo  = loOut;
  endtask

  int          lat;
  int          stalls;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy1;
  logic [1:0]  wen;
  logic        late_wen;
  logic [31:0] hold_lo;
  int          seen;

  initial begin
    vecs[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'd3, 32'h00000007, 32'h00000000, 1'b0, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000};
    vecs[5]  = '{2'd1, 32'h12345678, 32'h00000010, 1'b0, 32'h00000001, 32'h23456780};
    vecs[6]  = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8]  = '{2'd0, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
    vecs[9]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001};
    vecs[10] = '{2'd0, 32'h00001000, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'hFFFFF000};
    vecs[11] = '{2'd3, 32'hFFFFFFFF, 32'h00000010, 1'b0, 32'h0000000F, 32'h0FFFFFFF};
    vecs[12] = '{2'd3, 32'd100,      32'd7,        1'b1, 32'd2,        32'd14};

    rst = 1'b1; start = 1'b0; opSel = 2'b00; cancel = 1'b0; rsData = '0; rtData = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi",   hiOut, 32'd0);
    chk("rst_lo",   loOut, 32'd0);
    chk("rst_hiw",  32'(hiWena), 32'd0);
    chk("rst_low",  32'(loWena), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].poke,
            lat, stalls, hi, lo, busy1, wen, late_wen, hold_lo);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].op)));
      chk($sformatf("v%0d_stall", i), 32'(stalls), 32'(exp_lat(vecs[i].op)));
      chk($sformatf("v%0d_busy", i), 32'(busy1), (exp_lat(vecs[i].op) > 1) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_wen", i), 32'(wen), 32'd3);
      chk($sformatf("v%0d_pulse1", i), 32'(late_wen), 32'd0);
      chk($sformatf("v%0d_hold", i), hold_lo, vecs[i].lo);
    end

    // Cancel a DIVU at counter 10, then start MULTU straight away
    seen = 0;
    @(posedge clk); #1;
    start = 1'b1; opSel = 2'b11; rsData = 32'd100; rtData = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 10) cancel = 1'b1;
      #1 if (hiWena || loWena) seen++;
    end
    @(posedge clk); #1;
    cancel = 1'b0;
    #1;
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_wen", 32'(seen) + 32'(hiWena | loWena), 32'd0);
    chk("cancel_hi", hiOut, vecs[NV-1].hi);
    chk("cancel_lo", loOut, vecs[NV-1].lo);
    do_op(2'b01, 32'd6, 32'd7, 1'b0, lat, stalls, hi, lo, busy1, wen, late_wen, hold_lo);
    chk("after_cancel_hi", hi, 32'd0);
    chk("after_cancel_lo", lo, 32'd42);
    chk("after_cancel_lat", 32'(lat), 32'(exp_lat(2'b01)));

    // Reset in the middle of a divide
    @(posedge clk); #1;
    start = 1'b1; opSel = 2'b11; rsData = 32'd1000; rtData = 32'd3;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstmid_hi", hiOut, 32'd0);
    chk("rstmid_lo", loOut, 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (hiWena || loWena) seen++;
    end
    chk("rstmid_nowen", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
